aes_256_sched: RTL and testbench

//  Two-requester scheduler/front end for the fully pipelined, fixed-latency aes_256 core.

---
 rtl/aes_256_sched_if.sv | 35 +++
 rtl/aes_256_sched.sv | 104 ++++++++++
 tb/tb_aes_256_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_256_sched_if.sv
// rtl/aes_256_sched_if.sv - request, core and response signal bundle for aes_256_sched
interface aes_256_sched_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_state;
    logic [255:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_state;
    logic [255:0] req1_key;
    logic [127:0] core_state;
    logic [255:0] core_key;
    logic [127:0] core_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         busy;

    modport slave (
        input  req0_valid, req0_state, req0_key,
        input  req1_valid, req1_state, req1_key,
        input  core_out, rsp_ready,
        output req0_ready, req1_ready, core_state, core_key,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_state, req0_key,
        output req1_valid, req1_state, req1_key,
        output core_out, rsp_ready,
        input  req0_ready, req1_ready, core_state, core_key,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/aes_256_sched.sv
// rtl/aes_256_sched.sv - two-channel round-robin front end for a fixed-latency aes_256 core
// Credits cover in-flight blocks plus stored results, so the output FIFO can never overflow.
module aes_256_sched #(
    parameter int LATENCY   = 29,
    parameter int OUT_DEPTH = 32
) (
    input logic            clk,
    input logic            rst,
    aes_256_sched_if.slave bus
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    logic               rr_last_q, rr_last_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [128:0]       fifo_mem [OUT_DEPTH];

    logic               can_issue;
    logic               any_valid;
    logic               grant_id;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [SUM_W-1:0]   credit_used;

    always_comb begin
        credit_used   = SUM_W'(inflight_q) + SUM_W'(count_q);
        can_issue     = credit_used < SUM_W'(OUT_DEPTH);
        any_valid     = bus.req0_valid | bus.req1_valid;
        grant_id      = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~rr_last_q;
        end
        accept        = can_issue & any_valid;
        push          = tag_vld_q[LATENCY-1];
        fifo_nonempty = (count_q != '0);
        pop           = fifo_nonempty & bus.rsp_ready;
    end

    always_comb begin
        rr_last_d  = accept ? grant_id : rr_last_q;
        tag_vld_d  = {tag_vld_q[LATENCY-2:0], accept};
        tag_id_d   = {tag_id_q[LATENCY-2:0], grant_id};
        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q  <= 1'b1;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // The tag pipe is the only qualifier of core_out, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {tag_id_q[LATENCY-1], bus.core_out};
        end
    end

    assign bus.req0_ready = accept & ~grant_id;
    assign bus.req1_ready = accept & grant_id;
    assign bus.core_state = accept ? (grant_id ? bus.req1_state : bus.req0_state) : '0;
    assign bus.core_key   = accept ? (grant_id ? bus.req1_key : bus.req0_key) : '0;
    assign bus.rsp_valid  = fifo_nonempty;
    assign bus.rsp_id     = fifo_mem[rd_ptr_q][128];
    assign bus.rsp_data   = fifo_mem[rd_ptr_q][127:0];
    assign bus.busy       = (inflight_q != '0) | fifo_nonempty;

    assert property (@(posedge clk) disable iff (rst) !(push && count_q == CNT_W'(OUT_DEPTH)));
endmodule

// File: tb/tb_aes_256_sched.sv
// tb/tb_aes_256_sched.sv - directed and random checks of aes_256_sched against an AES-256 model
module tb_aes_256_sched;
    localparam int LAT   = 29;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic rst;
    aes_256_sched_if bus ();

    aes_256_sched #(.LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]   sbox_t [256];
    logic [127:0] core_pipe [LAT];
    exp_t         exp_q [$];
    int           tests_run;
    int           tests_failed;
    int           n_acc0;
    int           n_acc1;
    int           n_pop;
    logic         acc0;
    logic         acc1;
    logic         last_grant;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        s = 8'h63;
        for (int r = 0; r < 5; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_t[s[4*(((j/4) + (j%4)) % 4) + (j%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                if (r != 14) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c]   = a0;
                    s[4*c+1] = a1;
                    s[4*c+2] = a2;
                    s[4*c+3] = a3;
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    // Stand-in for the aes_256 core: samples its inputs every edge, result LAT-1 edges later.
    assign bus.core_out = core_pipe[LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= aes256(bus.core_state, bus.core_key);
        for (int k = LAT - 1; k > 0; k--) core_pipe[k] <= core_pipe[k-1];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc0 = bus.req0_valid && bus.req0_ready;
        acc1 = bus.req1_valid && bus.req1_ready;
        chk("single_grant", 128'(acc0 & acc1), 128'(0));
        if (acc0) begin
            e.id   = 1'b0;
            e.data = aes256(bus.req0_state, bus.req0_key);
            exp_q.push_back(e);
            n_acc0++;
            last_grant = 1'b0;
        end
        if (acc1) begin
            e.id   = 1'b1;
            e.data = aes256(bus.req1_state, bus.req1_key);
            exp_q.push_back(e);
            n_acc1++;
            last_grant = 1'b1;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_pop++;
            chk("rsp_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                chk("rsp_data", bus.rsp_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ch(input bit ch);
        logic [127:0] st;
        logic [255:0] ky;
        st = {$urandom(), $urandom(), $urandom(), $urandom()};
        ky = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        if (ch) begin
            bus.req1_state = st;
            bus.req1_key   = ky;
        end else begin
            bus.req0_state = st;
            bus.req0_key   = ky;
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        bus.rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.busy) && guard < 300) begin
            tick();
            guard++;
        end
        chk(tag, 128'({exp_q.size() == 0, bus.busy}), 128'(2'b10));
    endtask

    task automatic run_t1(input string pfx);
        bus.req0_state = 128'h00112233445566778899aabbccddeeff;
        bus.req0_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        bus.req0_valid = 1'b1;
        bus.rsp_ready  = 1'b0;
        tick();
        chk({pfx, "_accept"}, 128'(acc0), 128'(1));
        bus.req0_valid = 1'b0;
        repeat (LAT - 1) tick();
        chk({pfx, "_not_early"}, 128'(bus.rsp_valid), 128'(0));
        tick();
        chk({pfx, "_valid"}, 128'(bus.rsp_valid), 128'(1));
        chk({pfx, "_data"}, bus.rsp_data, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk({pfx, "_id"}, 128'(bus.rsp_id), 128'(0));
        drain({pfx, "_drain"});
    endtask

    initial begin
        int a;
        int p0;
        int guard;
        int rv;
        logic exp_g;

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        tests_run      = 0;
        tests_failed   = 0;
        n_acc0         = 0;
        n_acc1         = 0;
        n_pop          = 0;
        acc0           = 1'b0;
        acc1           = 1'b0;
        last_grant     = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_state = '0;
        bus.req0_key   = '0;
        bus.req1_state = '0;
        bus.req1_key   = '0;
        bus.rsp_ready  = 1'b0;
        rst            = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_ready0", 128'(bus.req0_ready), 128'(0));
        chk("rst_ready1", 128'(bus.req1_ready), 128'(0));

        rand_ch(0);
        rand_ch(1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("first_pref_ch0", 128'(bus.req0_ready), 128'(1));
        chk("first_pref_ch1", 128'(bus.req1_ready), 128'(0));
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        run_t1("t1");

        rand_ch(0);
        rand_ch(1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            exp_g = ~last_grant;
            tick();
            chk("t2_accept_each_cycle", 128'(acc0 | acc1), 128'(1));
            chk("t2_grant_alternates", 128'(acc1), 128'(exp_g));
            if (acc0) rand_ch(0);
            if (acc1) rand_ch(1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain("t2_drain");

        bus.rsp_ready  = 1'b0;
        a              = n_acc0;
        rand_ch(0);
        bus.req0_valid = 1'b1;
        repeat (80) begin
            tick();
            if (acc0) rand_ch(0);
        end
        chk("t3_accepts", 128'(n_acc0 - a), 128'(DEPTH));
        chk("t3_ready_low", 128'(bus.req0_ready), 128'(0));
        p0            = n_pop;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t3_no_bypass", 128'(bus.req0_ready), 128'(0));
        tick();
        chk("t3_credit_back", 128'(bus.req0_ready), 128'(1));
        bus.req0_valid = 1'b0;
        drain("t3_drain");
        chk("t3_pops", 128'(n_pop - p0), 128'(DEPTH));

        bus.rsp_ready  = 1'b0;
        a              = 0;
        guard          = 0;
        rand_ch(0);
        bus.req0_valid = 1'b1;
        while (a < DEPTH - 1 && guard < 100) begin
            tick();
            guard++;
            if (acc0) begin
                a++;
                rand_ch(0);
            end
        end
        bus.req0_valid = 1'b0;
        chk("t4_fill_31", 128'(a), 128'(DEPTH - 1));
        repeat (LAT + 2) tick();
        bus.req0_valid = 1'b1;
        tick();
        chk("t4_last_accept", 128'(acc0), 128'(1));
        bus.req0_valid = 1'b0;
        repeat (LAT - 1) tick();
        rand_ch(0);
        bus.req0_valid = 1'b1;
        #1;
        chk("t4_pool_exhausted", 128'(bus.req0_ready), 128'(0));
        p0            = n_pop;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        chk("t4_count_stays_31", 128'(bus.req0_ready), 128'(1));
        bus.req0_valid = 1'b0;
        drain("t4_drain");
        chk("t4_pops", 128'(n_pop - p0), 128'(DEPTH));

        bus.rsp_ready  = 1'b1;
        a              = 0;
        guard          = 0;
        rand_ch(0);
        bus.req0_valid = 1'b1;
        while (a < 10 && guard < 100) begin
            tick();
            guard++;
            if (acc0) begin
                a++;
                rand_ch(0);
            end
        end
        bus.req0_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        exp_q.delete();
        last_grant = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        rv  = 0;
        repeat (60) begin
            tick();
            if (bus.rsp_valid) rv++;
        end
        chk("t5_no_stale_rsp", 128'(rv), 128'(0));
        chk("t5_busy", 128'(bus.busy), 128'(0));
        run_t1("t5_t1");

        a              = 0;
        guard          = 0;
        p0             = n_pop;
        rand_ch(1);
        bus.req1_valid = 1'b1;
        while (a < 100 && guard < 3000) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (acc1) begin
                a++;
                if (a < 100) rand_ch(1);
                else bus.req1_valid = 1'b0;
            end
        end
        bus.req1_valid = 1'b0;
        chk("t6_accepts", 128'(a), 128'(100));
        drain("t6_drain");
        chk("t6_pops", 128'(n_pop - p0), 128'(100));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
